// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game types, direction indices, default video geometry and clamp helpers
package game_pkg;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_PAUSE = 1'b1
   } state_t;

   localparam int DIR_U    = 0;
   localparam int DIR_D    = 1;
   localparam int DIR_L    = 2;
   localparam int DIR_R    = 3;
   localparam int NUM_DIRS = 4;

   localparam int DEF_H_ACTIVE = 800;
   localparam int DEF_V_ACTIVE = 600;
   localparam int DEF_BOX_SIZE = 32;

   // Hold counter width; covers HOLD_FRAMES up to 31.
   localparam int CNT_W = 5;

   // Subtract with a floor at zero, so the sprite never wraps past the top/left edge.
   function automatic logic [11:0] clamp_dec(input logic [11:0] v, input logic [11:0] step);
      return (v < step) ? 12'd0 : (v - step);
   endfunction

   // Add with a ceiling, so the sprite never leaves the visible area bottom/right.
   function automatic logic [11:0] clamp_inc(input logic [11:0] v, input logic [11:0] step,
                                             input logic [11:0] lim);
      logic [11:0] sum;
      sum = v + step;
      return (sum > lim) ? lim : sum;
   endfunction

endpackage

// File: rtl/btn_cmd.sv
// rtl/btn_cmd.sv - per-button edge capture, hold auto-repeat and per-frame command
module btn_cmd
   import game_pkg::*;
#(
   parameter int HOLD_FRAMES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic level,
   input  logic tick,
   output logic cmd
);

   localparam logic [CNT_W-1:0] C_HOLD = CNT_W'(HOLD_FRAMES);

   logic             r_hist;
   logic             r_pend;
   logic [CNT_W-1:0] r_cnt;
   logic             w_rise;

   // History clears to 0 so a level already high at reset release reads as a press.
   assign w_rise = level & ~r_hist;

   // The command seen at a tick uses the counter value before this tick's increment.
   assign cmd = r_pend | (level & (r_cnt == C_HOLD));

   // Edge history register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_hist <= 1'b0;
      else       r_hist <= level;
   end

   // Pending press: a fresh edge wins over the tick's clear and survives to the next tick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       r_pend <= 1'b0;
      else if (w_rise) r_pend <= 1'b1;
      else if (tick)   r_pend <= 1'b0;
   end

   // Saturating count of consecutive frames the level was high at a tick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (tick) begin
         if (!level)             r_cnt <= '0;
         else if (r_cnt != C_HOLD) r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/move_sched.sv
// rtl/move_sched.sv - frame-synchronous move scheduler and RUN/PAUSE sequencer for the sprite
module move_sched
   import game_pkg::*;
#(
   parameter int H_ACTIVE    = DEF_H_ACTIVE,
   parameter int V_ACTIVE    = DEF_V_ACTIVE,
   parameter int BOX_SIZE    = DEF_BOX_SIZE,
   parameter int STEP        = 4,
   parameter int START_X     = 384,
   parameter int START_Y     = 284,
   parameter int HOLD_FRAMES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] x,
   input  logic [10:0] y,
   input  logic        btn_u,
   input  logic        btn_d,
   input  logic        btn_l,
   input  logic        btn_r,
   output logic [10:0] box_x,
   output logic [10:0] box_y,
   output logic        frame_tick,
   output logic        paused,
   output logic        moved
);

   localparam logic [10:0] C_H_ACT = 11'(H_ACTIVE);
   localparam logic [10:0] C_V_ACT = 11'(V_ACTIVE);
   localparam logic [11:0] C_STEP  = 12'(STEP);
   localparam logic [11:0] C_X_MAX = 12'(H_ACTIVE - BOX_SIZE);
   localparam logic [11:0] C_Y_MAX = 12'(V_ACTIVE - BOX_SIZE);
   localparam logic [10:0] C_X0    = 11'(START_X);
   localparam logic [10:0] C_Y0    = 11'(START_Y);

   logic                w_eob;
   logic                r_eob_d;
   logic                r_tick;
   logic [NUM_DIRS-1:0] w_lvl;
   logic [NUM_DIRS-1:0] w_cmd;
   logic                w_toggle;
   logic                w_apply;
   state_t              r_state;
   state_t              w_state_nxt;
   logic [10:0]         r_box_x;
   logic [10:0]         r_box_y;
   logic                r_moved;
   logic [10:0]         w_x_nxt;
   logic [10:0]         w_y_nxt;

   assign w_eob = (x == C_H_ACT) && (y == C_V_ACT);

   assign w_lvl[DIR_U] = btn_u;
   assign w_lvl[DIR_D] = btn_d;
   assign w_lvl[DIR_L] = btn_l;
   assign w_lvl[DIR_R] = btn_r;

   for (genvar g = 0; g < NUM_DIRS; g++) begin : g_btn
      btn_cmd #(
         .HOLD_FRAMES(HOLD_FRAMES)
      ) u_btn_cmd (
         .clk  (clk),
         .reset(reset),
         .level(w_lvl[g]),
         .tick (r_tick),
         .cmd  (w_cmd[g])
      );
   end

   // Left and right together is the pause toggle, never a horizontal move.
   assign w_toggle = w_cmd[DIR_L] & w_cmd[DIR_R];

   // Registered rising edge of end-of-active: one pulse per frame however long eob holds.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_eob_d <= 1'b0;
         r_tick  <= 1'b0;
      end else begin
         r_eob_d <= w_eob;
         r_tick  <= w_eob & ~r_eob_d;
      end
   end

   // Game state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_RUN;
      else       r_state <= w_state_nxt;
   end

   // Next state: only a tick carrying the L+R toggle flips RUN/PAUSE.
   always_comb begin
      w_state_nxt = r_state;
      if (r_tick && w_toggle)
         w_state_nxt = (r_state == ST_RUN) ? ST_PAUSE : ST_RUN;
   end

   // Outputs: decide whether this tick moves the sprite and compute clamped targets.
   always_comb begin
      w_apply = r_tick && (r_state == ST_RUN) && !w_toggle;
      w_x_nxt = r_box_x;
      w_y_nxt = r_box_y;
      if (w_cmd[DIR_L])
         w_x_nxt = 11'(clamp_dec({1'b0, r_box_x}, C_STEP));
      else if (w_cmd[DIR_R])
         w_x_nxt = 11'(clamp_inc({1'b0, r_box_x}, C_STEP, C_X_MAX));
      if (w_cmd[DIR_U] && !w_cmd[DIR_D])
         w_y_nxt = 11'(clamp_dec({1'b0, r_box_y}, C_STEP));
      else if (w_cmd[DIR_D] && !w_cmd[DIR_U])
         w_y_nxt = 11'(clamp_inc({1'b0, r_box_y}, C_STEP, C_Y_MAX));
   end

   // Position and moved flag change only at a tick, i.e. at the start of vertical blanking.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_box_x <= C_X0;
         r_box_y <= C_Y0;
         r_moved <= 1'b0;
      end else if (w_apply) begin
         r_box_x <= w_x_nxt;
         r_box_y <= w_y_nxt;
         r_moved <= (w_x_nxt != r_box_x) || (w_y_nxt != r_box_y);
      end else if (r_tick) begin
         r_moved <= 1'b0;
      end
   end

   assign box_x      = r_box_x;
   assign box_y      = r_box_y;
   assign moved      = r_moved;
   assign frame_tick = r_tick;
   assign paused     = (r_state == ST_PAUSE);

endmodule

// File: tb/tb_move_sched.sv
// tb/tb_move_sched.sv - scoreboard bench for move_sched with directed frame vectors
module tb_move_sched;

   typedef struct {
      int bx;
      int by;
      int mv;
      int ps;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [10:0] x;
   logic [10:0] y;
   logic        btn_u;
   logic        btn_d;
   logic        btn_l;
   logic        btn_r;
   logic [10:0] box_x;
   logic [10:0] box_y;
   logic        frame_tick;
   logic        paused;
   logic        moved;

   int   n_checks = 0;
   int   n_errors = 0;
   int   n_ticks  = 0;
   int   n_frames = 0;
   exp_t q[$];

   move_sched dut (
      .clk       (clk),
      .reset     (reset),
      .x         (x),
      .y         (y),
      .btn_u     (btn_u),
      .btn_d     (btn_d),
      .btn_l     (btn_l),
      .btn_r     (btn_r),
      .box_x     (box_x),
      .box_y     (box_y),
      .frame_tick(frame_tick),
      .paused    (paused),
      .moved     (moved)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: on each tick, pop the expected post-tick state and compare one cycle later.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (frame_tick === 1'b1) begin
            n_ticks++;
            @(negedge clk);
            chk("tick_width", int'(frame_tick), 0);
            if (q.size() == 0) begin
               chk("unexpected_tick", 1, 0);
            end else begin
               e = q.pop_front();
               chk("box_x", int'(box_x), e.bx);
               chk("box_y", int'(box_y), e.by);
               chk("moved", int'(moved), e.mv);
               chk("paused", int'(paused), e.ps);
            end
         end
      end
   end

   // One frame: queue the expectation, hold eob for three cycles, then idle.
   task automatic frame(input int ex, input int ey, input int em, input int ep, input bit d_at_tick);
      int t0;
      exp_t e;
      t0 = n_ticks;
      e.bx = ex; e.by = ey; e.mv = em; e.ps = ep;
      q.push_back(e);
      n_frames++;
      @(negedge clk); x = 11'd800; y = 11'd600;
      @(negedge clk); if (d_at_tick) btn_d = 1'b1;
      @(negedge clk);
      @(negedge clk); x = 11'd0; y = 11'd0;
      repeat (4) @(negedge clk);
      chk("ticks_per_frame", n_ticks - t0, 1);
   endtask

   // Mid-frame press of the buttons in m = {r,l,d,u} for three clocks.
   task automatic pulse(input logic [3:0] m);
      @(negedge clk);
      btn_u = m[0]; btn_d = m[1]; btn_l = m[2]; btn_r = m[3];
      repeat (3) @(negedge clk);
      btn_u = 1'b0; btn_d = 1'b0; btn_l = 1'b0; btn_r = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #500us;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int ey;
      int em;
      reset = 1'b1; x = '0; y = '0;
      btn_u = 1'b0; btn_d = 1'b0; btn_l = 1'b0; btn_r = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_box_x", int'(box_x), 384);
      chk("rst_box_y", int'(box_y), 284);
      chk("rst_tick", int'(frame_tick), 0);
      chk("rst_paused", int'(paused), 0);
      chk("rst_moved", int'(moved), 0);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      // idle frames
      frame(384, 284, 0, 0, 0);
      frame(384, 284, 0, 0, 0);

      // single right press, then a quiet frame
      pulse(4'b1000);
      frame(388, 284, 1, 0, 0);
      frame(388, 284, 0, 0, 0);

      // hold up: move at tick 1, repeat from tick 17, clamp at 0
      @(negedge clk); btn_u = 1'b1;
      for (int k = 1; k <= 88; k++) begin
         if (k < 17) ey = 280;
         else        ey = (280 - 4 * (k - 16) < 0) ? 0 : 280 - 4 * (k - 16);
         em = (k == 1 || (k >= 17 && k <= 86)) ? 1 : 0;
         frame(388, ey, em, 0, 0);
      end
      @(negedge clk); btn_u = 1'b0;
      frame(388, 0, 0, 0, 0);

      // right presses up to the edge
      for (int i = 1; i <= 94; i++) begin
         pulse(4'b1000);
         frame(388 + 4 * i, 0, 1, 0, 0);
      end
      pulse(4'b1000);
      frame(768, 0, 1, 0, 0);
      pulse(4'b1000);
      frame(768, 0, 0, 0, 0);

      // down twice, then diagonal left+down
      pulse(4'b0010);
      frame(768, 4, 1, 0, 0);
      pulse(4'b0010);
      frame(768, 8, 1, 0, 0);
      pulse(4'b0110);
      frame(764, 12, 1, 0, 0);

      // pause toggle, ignored press, resume, then a move
      pulse(4'b1100);
      frame(764, 12, 0, 1, 0);
      pulse(4'b0001);
      frame(764, 12, 0, 1, 0);
      pulse(4'b1100);
      frame(764, 12, 0, 0, 0);
      pulse(4'b0001);
      frame(764, 8, 1, 0, 0);

      // down edge in the tick cycle is deferred to the next tick
      frame(764, 8, 0, 0, 1);
      frame(764, 12, 1, 0, 0);
      for (int k = 0; k < 8; k++) frame(764, 12, 0, 0, 0);

      // reset mid-hold
      @(negedge clk); x = 11'd100; y = 11'd50; reset = 1'b1;
      #1;
      chk("midrst_box_x", int'(box_x), 384);
      chk("midrst_box_y", int'(box_y), 284);
      chk("midrst_paused", int'(paused), 0);
      chk("midrst_moved", int'(moved), 0);
      repeat (2) @(negedge clk);
      x = '0; y = '0; reset = 1'b0;

      // held level counts as a fresh press; hold counter restarts from 0
      for (int k = 1; k <= 17; k++) begin
         if (k == 1)       frame(384, 288, 1, 0, 0);
         else if (k < 17)  frame(384, 288, 0, 0, 0);
         else              frame(384, 292, 1, 0, 0);
      end
      @(negedge clk); btn_d = 1'b0;
      frame(384, 292, 0, 0, 0);

      repeat (5) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      chk("total_ticks", n_ticks, n_frames);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
